// File: rtl/bus_xbar_rr_if.sv
// Bus bundle for bus_xbar_rr: per-master request lanes, shared slave-side bus, completion to the owner.
// Ports: bus_m_* (master lanes, packed i*W), bus_s_* (shared slave bus / per-slave responses), bus_rdy/rd_data/err.
// slave modport = interconnect's view; master modport = environment view (masters plus slaves), its mirror.
interface bus_xbar_rr_if #(
  parameter int NUM_M  = 4,
  parameter int NUM_S  = 8,
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32
);
  logic [NUM_M-1:0]        bus_m_req;
  logic [NUM_M*ADDR_W-1:0] bus_m_addr;
  logic [NUM_M-1:0]        bus_m_as;
  logic [NUM_M-1:0]        bus_m_rw;
  logic [NUM_M*DATA_W-1:0] bus_m_wr_data;
  logic [NUM_M-1:0]        bus_m_grnt;

  logic [ADDR_W-1:0]       bus_s_addr;
  logic                    bus_s_as;
  logic                    bus_s_rw;
  logic [DATA_W-1:0]       bus_s_wr_data;
  logic [NUM_S-1:0]        bus_s_cs;
  logic [NUM_S*DATA_W-1:0] bus_s_rd_data;
  logic [NUM_S-1:0]        bus_s_rdy;

  logic                    bus_rdy;
  logic [DATA_W-1:0]       bus_rd_data;
  logic                    bus_err;

  modport slave (
    input  bus_m_req, bus_m_addr, bus_m_as, bus_m_rw, bus_m_wr_data,
    input  bus_s_rd_data, bus_s_rdy,
    output bus_m_grnt, bus_s_addr, bus_s_as, bus_s_rw, bus_s_wr_data, bus_s_cs,
    output bus_rdy, bus_rd_data, bus_err
  );

  modport master (
    output bus_m_req, bus_m_addr, bus_m_as, bus_m_rw, bus_m_wr_data,
    output bus_s_rd_data, bus_s_rdy,
    input  bus_m_grnt, bus_s_addr, bus_s_as, bus_s_rw, bus_s_wr_data, bus_s_cs,
    input  bus_rdy, bus_rd_data, bus_err
  );
endinterface

// File: rtl/bus_xbar_rr.sv
// Shared-bus interconnect: round-robin grant held across an outstanding access, address decode, watchdog.
// Latency: grant one cycle after request; completion combinational from slave rdy; timeout after TIMEOUT pending cycles.
// Backpressure: one outstanding access; strobes while pending or from non-owners are ignored.
// Ports: clk, rest (sync active-high reset), xb (bus_xbar_rr_if.slave) carrying all master/slave signals.
module bus_xbar_rr #(
  parameter int NUM_M   = 4,
  parameter int NUM_S   = 8,
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rest,
  bus_xbar_rr_if.slave xb
);
  localparam int          SEL_W = $clog2(NUM_S);
  localparam int          OWN_W = $clog2(NUM_M);
  localparam logic [15:0] TMO   = 16'(TIMEOUT);

  typedef enum logic {IDLE, OWN} state_t;

  state_t             state, state_nxt;
  logic [OWN_W-1:0]   last_owner, last_owner_nxt;
  logic [NUM_M-1:0]   grnt, grnt_nxt;
  logic               pending;
  logic [SEL_W-1:0]   pend_sel;
  logic [15:0]        cnt;

  logic [OWN_W-1:0]   rr_pick;
  logic               rr_found;
  int                 rr_best;
  int                 rr_dist;

  logic [ADDR_W-1:0]  s_addr;
  logic               s_as;
  logic               s_rw;
  logic [DATA_W-1:0]  s_wr_data;
  logic               owner_req;

  logic [SEL_W-1:0]   dec;
  logic [SEL_W-1:0]   sel;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_rdy;
  logic               start;
  logic               active;
  logic               timeout;
  logic               hold;

  // Round-robin pick: the requester closest after last_owner going upward with wrap.
  // Distance runs 1..NUM_M so last_owner itself is considered last.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = last_owner;
    rr_best  = NUM_M + 1;
    rr_dist  = 0;
    for (int i = 0; i < NUM_M; i++) begin
      if (i > int'(last_owner)) rr_dist = i - int'(last_owner);
      else                      rr_dist = i - int'(last_owner) + NUM_M;
      if (xb.bus_m_req[i] && rr_dist < rr_best) begin
        rr_best  = rr_dist;
        rr_pick  = OWN_W'(i);
        rr_found = 1'b1;
      end
    end
  end

  // Owner mux gated by the registered one-hot grant; all-zero without an owner.
  always_comb begin
    s_addr    = '0;
    s_as      = 1'b0;
    s_rw      = 1'b0;
    s_wr_data = '0;
    owner_req = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      if (grnt[i]) begin
        s_addr    = xb.bus_m_addr[i*ADDR_W +: ADDR_W];
        s_as      = xb.bus_m_as[i];
        s_rw      = xb.bus_m_rw[i];
        s_wr_data = xb.bus_m_wr_data[i*DATA_W +: DATA_W];
        owner_req = xb.bus_m_req[i];
      end
    end
  end

  assign dec     = s_addr[ADDR_W-1 -: SEL_W];
  assign start   = s_as & ~pending;
  assign active  = pending | start;
  // While pending the latched select wins over whatever the owner now drives.
  assign sel     = pending ? pend_sel : dec;
  assign sel_rdy = xb.bus_s_rdy[sel];

  always_comb begin
    sel_data = '0;
    for (int j = 0; j < NUM_S; j++) begin
      if (sel == SEL_W'(j)) sel_data = xb.bus_s_rd_data[j*DATA_W +: DATA_W];
    end
  end

  // A slave rdy in the timeout cycle takes precedence over the error completion.
  assign timeout = pending & (TMO != 16'd0) & (cnt == TMO) & ~sel_rdy;

  // Keep the grant while the owner requests, an access is outstanding, or one is just starting without rdy.
  assign hold = owner_req | pending | (start & ~sel_rdy);

  assign xb.bus_m_grnt    = grnt;
  assign xb.bus_s_addr    = s_addr;
  assign xb.bus_s_as      = s_as;
  assign xb.bus_s_rw      = s_rw;
  assign xb.bus_s_wr_data = s_wr_data;
  assign xb.bus_s_cs      = active ? (NUM_S'(1) << sel) : '0;
  assign xb.bus_rdy       = (active & sel_rdy) | timeout;
  assign xb.bus_rd_data   = (active & sel_rdy) ? sel_data : '0;
  assign xb.bus_err       = timeout;

  // Arbiter next state; a releasing owner hands over directly without an idle cycle.
  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    grnt_nxt       = grnt;
    case (state)
      IDLE: begin
        if (rr_found) begin
          state_nxt      = OWN;
          grnt_nxt       = NUM_M'(1) << rr_pick;
          last_owner_nxt = rr_pick;
        end
      end
      OWN: begin
        if (!hold) begin
          if (rr_found) begin
            grnt_nxt       = NUM_M'(1) << rr_pick;
            last_owner_nxt = rr_pick;
          end else begin
            state_nxt = IDLE;
            grnt_nxt  = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      state      <= IDLE;
      last_owner <= OWN_W'(NUM_M - 1);
      grnt       <= '0;
      pending    <= 1'b0;
      pend_sel   <= '0;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      grnt       <= grnt_nxt;
      if (pending) begin
        if (xb.bus_rdy) pending <= 1'b0;
        else if (cnt != 16'hFFFF) cnt <= cnt + 16'd1;
      end else if (start && !sel_rdy) begin
        pending  <= 1'b1;
        pend_sel <= dec;
        cnt      <= 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_bus_xbar_rr.sv
// Bench for bus_xbar_rr: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a behavioural model (owner as integer, round-robin by modular scan).
module tb_bus_xbar_rr;
  localparam int NUM_M   = 4;
  localparam int NUM_S   = 8;
  localparam int ADDR_W  = 30;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;
  localparam int SEL_W   = $clog2(NUM_S);

  logic clk;
  logic rest;
  int   n_checks = 0;
  int   n_err    = 0;
  logic chk_en   = 1'b0;

  bus_xbar_rr_if #(.NUM_M(NUM_M), .NUM_S(NUM_S), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_i ();

  bus_xbar_rr #(.NUM_M(NUM_M), .NUM_S(NUM_S), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rest (rest),
    .xb   (bus_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_M-1:0]  grnt;
    logic [ADDR_W-1:0] saddr;
    logic              sas;
    logic              srw;
    logic [DATA_W-1:0] swd;
    logic [NUM_S-1:0]  cs;
    logic              rdy;
    logic              err;
    logic [DATA_W-1:0] rdat;
    logic              start;
    logic              hold;
    logic [SEL_W-1:0]  dec;
  } exp_t;

  // Model state: owner -1 means nobody holds the bus.
  int mdl_owner = -1;
  int mdl_last  = NUM_M - 1;
  bit mdl_pend  = 1'b0;
  int mdl_psel  = 0;
  int mdl_cnt   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t eval_model();
    exp_t e;
    int   o;
    int   d;
    e = '0;
    o = mdl_owner;
    if (o >= 0) begin
      e.grnt[o] = 1'b1;
      e.saddr   = bus_i.bus_m_addr[o*ADDR_W +: ADDR_W];
      e.sas     = bus_i.bus_m_as[o];
      e.srw     = bus_i.bus_m_rw[o];
      e.swd     = bus_i.bus_m_wr_data[o*DATA_W +: DATA_W];
    end
    d       = int'(e.saddr / (2 ** (ADDR_W - SEL_W)));
    e.dec   = SEL_W'(d);
    e.start = e.sas && !mdl_pend;
    if (mdl_pend) begin
      e.cs[mdl_psel] = 1'b1;
      if (bus_i.bus_s_rdy[mdl_psel]) begin
        e.rdy  = 1'b1;
        e.rdat = bus_i.bus_s_rd_data[mdl_psel*DATA_W +: DATA_W];
      end else if (TIMEOUT != 0 && mdl_cnt == TIMEOUT) begin
        e.rdy = 1'b1;
        e.err = 1'b1;
      end
    end else if (e.start) begin
      e.cs[d] = 1'b1;
      if (bus_i.bus_s_rdy[d]) begin
        e.rdy  = 1'b1;
        e.rdat = bus_i.bus_s_rd_data[d*DATA_W +: DATA_W];
      end
    end
    e.hold = (o >= 0) && (bus_i.bus_m_req[o] || mdl_pend || (e.start && !bus_i.bus_s_rdy[d]));
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    int   pick;
    e = eval_model();
    if (rest) begin
      chk_en    <= 1'b1;
      mdl_owner <= -1;
      mdl_last  <= NUM_M - 1;
      mdl_pend  <= 1'b0;
      mdl_psel  <= 0;
      mdl_cnt   <= 0;
    end else begin
      if (mdl_pend) begin
        if (e.rdy) mdl_pend <= 1'b0;
        else mdl_cnt <= (mdl_cnt < 65535) ? mdl_cnt + 1 : 65535;
      end else if (e.start && !e.rdy) begin
        mdl_pend <= 1'b1;
        mdl_psel <= int'(e.dec);
        mdl_cnt  <= 1;
      end
      if (!e.hold) begin
        pick = -1;
        for (int k = 1; k <= NUM_M; k++)
          if (pick < 0 && bus_i.bus_m_req[(mdl_last + k) % NUM_M]) pick = (mdl_last + k) % NUM_M;
        mdl_owner <= pick;
        if (pick >= 0) mdl_last <= pick;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      e = eval_model();
      chk("mdl_grnt",   64'(bus_i.bus_m_grnt), 64'(e.grnt));
      chk("mdl_s_addr", 64'(bus_i.bus_s_addr), 64'(e.saddr));
      chk("mdl_s_ctl",  64'({bus_i.bus_s_as, bus_i.bus_s_rw, bus_i.bus_s_cs}), 64'({e.sas, e.srw, e.cs}));
      chk("mdl_s_wd",   64'(bus_i.bus_s_wr_data), 64'(e.swd));
      chk("mdl_cpl",    64'({bus_i.bus_rdy, bus_i.bus_err}), 64'({e.rdy, e.err}));
      chk("mdl_rdat",   64'(bus_i.bus_rd_data), 64'(e.rdat));
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus_i.bus_m_req     = '0;
    bus_i.bus_m_addr    = '0;
    bus_i.bus_m_as      = '0;
    bus_i.bus_m_rw      = '0;
    bus_i.bus_m_wr_data = '0;
    bus_i.bus_s_rd_data = '0;
    bus_i.bus_s_rdy     = '0;
  endtask

  task automatic rand_cycle();
    rest = ($urandom_range(0, 199) == 0);
    for (int i = 0; i < NUM_M; i++) begin
      if ($urandom_range(0, 5) == 0) bus_i.bus_m_req[i] = ~bus_i.bus_m_req[i];
      bus_i.bus_m_as[i] = ($urandom_range(0, 3) == 0);
      bus_i.bus_m_rw[i] = 1'($urandom_range(0, 1));
      bus_i.bus_m_addr[i*ADDR_W +: ADDR_W]    = ADDR_W'($urandom);
      bus_i.bus_m_wr_data[i*DATA_W +: DATA_W] = $urandom;
    end
    for (int j = 0; j < NUM_S; j++) begin
      bus_i.bus_s_rdy[j] = ($urandom_range(0, 4) == 0);
      bus_i.bus_s_rd_data[j*DATA_W +: DATA_W] = $urandom;
    end
  endtask

  logic [NUM_M-1:0] order     [5];
  logic [NUM_M-1:0] exp_order [5];
  int               n_gr;

  initial begin
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int k = 0; k < 5; k++) order[k] = '0;
    clear_inputs();
    rest = 1'b1;
    repeat (3) nxt();
    mid();
    chk("rst_grnt", 64'(bus_i.bus_m_grnt), 64'd0);
    chk("rst_outs", 64'({bus_i.bus_rdy, bus_i.bus_err, bus_i.bus_s_cs, bus_i.bus_s_as}), 64'd0);

    // Masters 0 and 2 request together: m0 first, then direct handover to m2.
    nxt(); rest = 1'b0; bus_i.bus_m_req = 4'b0101;
    mid(); chk("grnt_latency", 64'(bus_i.bus_m_grnt), 64'd0);
    nxt(); bus_i.bus_m_req[0] = 1'b0;
    mid(); chk("grnt_m0", 64'(bus_i.bus_m_grnt), 64'b0001);
    nxt(); bus_i.bus_m_req[2] = 1'b0;
    mid(); chk("grnt_m2", 64'(bus_i.bus_m_grnt), 64'b0100);
    nxt(); bus_i.bus_m_req = 4'b0010;
    mid(); chk("grnt_idle", 64'(bus_i.bus_m_grnt), 64'd0);

    // m1 reads slave 6, rdy three cycles after the strobe; owner drops req while pending.
    nxt();
    bus_i.bus_m_as[1] = 1'b1;
    bus_i.bus_m_rw[1] = 1'b1;
    bus_i.bus_m_addr[1*ADDR_W +: ADDR_W] = 30'h3000_0004;
    bus_i.bus_m_req = 4'b1010;
    mid();
    chk("rd_grnt_m1", 64'(bus_i.bus_m_grnt), 64'b0010);
    chk("rd_cs_c0", 64'(bus_i.bus_s_cs), 64'h40);
    chk("rd_rdy_c0", 64'(bus_i.bus_rdy), 64'd0);
    nxt(); bus_i.bus_m_as = '0; bus_i.bus_m_req[1] = 1'b0;
    mid(); chk("rd_cs_c1", 64'(bus_i.bus_s_cs), 64'h40);
    nxt();
    mid(); chk("rd_cs_c2", 64'(bus_i.bus_s_cs), 64'h40);
    nxt();
    bus_i.bus_s_rdy[6] = 1'b1;
    bus_i.bus_s_rd_data[6*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
    mid();
    chk("rd_cs_c3", 64'(bus_i.bus_s_cs), 64'h40);
    chk("rd_cpl", 64'({bus_i.bus_rdy, bus_i.bus_err}), 64'b10);
    chk("rd_data", 64'(bus_i.bus_rd_data), 64'hDEAD_BEEF);
    nxt(); bus_i.bus_s_rdy = '0;
    mid();
    chk("hold_until_rdy", 64'(bus_i.bus_m_grnt), 64'b0010);
    chk("rd_after", 64'({bus_i.bus_rdy, bus_i.bus_s_cs}), 64'd0);

    // m3 writes slave 1, which never answers: watchdog after 4 pending cycles.
    nxt();
    bus_i.bus_m_as[3] = 1'b1;
    bus_i.bus_m_addr[3*ADDR_W +: ADDR_W] = 30'h0800_0000;
    bus_i.bus_m_wr_data[3*DATA_W +: DATA_W] = 32'hA5A5_0003;
    mid();
    chk("handover_m3", 64'(bus_i.bus_m_grnt), 64'b1000);
    chk("wr_cs", 64'(bus_i.bus_s_cs), 64'h02);
    chk("wr_data_out", 64'(bus_i.bus_s_wr_data), 64'hA5A5_0003);
    nxt(); bus_i.bus_m_as = '0;
    nxt(); nxt();
    mid(); chk("tmo_early", 64'(bus_i.bus_rdy), 64'd0);
    nxt();
    mid();
    chk("tmo_cpl", 64'({bus_i.bus_rdy, bus_i.bus_err}), 64'b11);
    chk("tmo_data", 64'(bus_i.bus_rd_data), 64'd0);
    nxt();
    mid(); chk("tmo_after", 64'({bus_i.bus_rdy, bus_i.bus_s_cs}), 64'd0);

    // Same access, rdy arrives exactly on the timeout cycle: normal completion.
    nxt(); bus_i.bus_m_as[3] = 1'b1;
    nxt(); bus_i.bus_m_as = '0;
    nxt(); nxt();
    nxt();
    bus_i.bus_s_rdy[1] = 1'b1;
    bus_i.bus_s_rd_data[1*DATA_W +: DATA_W] = 32'h1234_5678;
    mid();
    chk("tmo_race_cpl", 64'({bus_i.bus_rdy, bus_i.bus_err}), 64'b10);
    chk("tmo_race_data", 64'(bus_i.bus_rd_data), 64'h1234_5678);
    nxt(); bus_i.bus_s_rdy = '0;

    // Reset while pending: grant and pending drop, no late completion.
    nxt(); bus_i.bus_m_as[3] = 1'b1;
    nxt(); bus_i.bus_m_as = '0; rest = 1'b1;
    mid(); chk("rst_mid_cs", 64'(bus_i.bus_s_cs), 64'h02);
    nxt(); rest = 1'b0; bus_i.bus_m_req = '0; bus_i.bus_s_rdy[1] = 1'b1;
    mid();
    chk("rst_mid_grnt", 64'(bus_i.bus_m_grnt), 64'd0);
    chk("rst_mid_rdy", 64'({bus_i.bus_rdy, bus_i.bus_s_cs}), 64'd0);
    nxt();
    mid(); chk("rst_no_late", 64'(bus_i.bus_rdy), 64'd0);

    // Round robin: all request, each owner does one zero-wait access and releases.
    nxt(); rest = 1'b1; bus_i.bus_s_rdy = '0;
    nxt(); rest = 1'b0; bus_i.bus_m_req = '1; bus_i.bus_s_rdy = '1;
    n_gr = 0;
    for (int cyc = 0; cyc < 20 && n_gr < 5; cyc++) begin
      nxt();
      bus_i.bus_m_req = '1;
      bus_i.bus_m_as  = '0;
      if (bus_i.bus_m_grnt != '0) begin
        order[n_gr] = bus_i.bus_m_grnt;
        n_gr++;
        for (int i = 0; i < NUM_M; i++) begin
          if (bus_i.bus_m_grnt[i]) begin
            bus_i.bus_m_as[i]  = 1'b1;
            bus_i.bus_m_req[i] = 1'b0;
          end
        end
      end
    end
    chk("rr_count", 64'(n_gr), 64'd5);
    for (int k = 0; k < 5; k++) chk("rr_order", 64'(order[k]), 64'(exp_order[k]));

    nxt(); clear_inputs();
    repeat (3000) begin
      nxt();
      rand_cycle();
    end
    nxt();
    rest = 1'b0;
    mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
